// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and control-bundle bit layout for elastic stage registers
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  localparam int CTRL_W_DEF = 13;
  localparam int ZERO       = 0;
  localparam int BRANCH     = 1;
  localparam int MEMREAD    = 2;
  localparam int MEMTOREG   = 3;
  localparam int MEMWRITE   = 4;
  localparam int ALUSRC     = 5;
  localparam int REGWRITE   = 6;
  localparam int LUI        = 7;
  localparam int AUIPC      = 8;
  localparam int JAL        = 9;
  localparam int JALR       = 10;
  localparam int ALUOP_LO   = 11;
  localparam int ALUOP_HI   = 12;
endpackage

// File: rtl/pipe_stage_elastic_if.sv
// pipe_stage_elastic_if: upstream/downstream handshake, flush and stall-counter signals of one stage
interface pipe_stage_elastic_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_DATA = 3,
  parameter int RD_W   = 5,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W*N_DATA-1:0] in_data;
  logic [RD_W-1:0]          in_rd;
  logic [CTRL_W-1:0]        in_ctrl;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W*N_DATA-1:0] out_data;
  logic [RD_W-1:0]          out_rd;
  logic [CTRL_W-1:0]        out_ctrl;
  logic [CNT_W-1:0]         stall_cnt;
  logic                     stall_clr;
  modport master (
    output in_valid, in_data, in_rd, in_ctrl, flush, out_ready, stall_clr,
    input  in_ready, out_valid, out_data, out_rd, out_ctrl, stall_cnt
  );
  modport slave (
    input  in_valid, in_data, in_rd, in_ctrl, flush, out_ready, stall_clr,
    output in_ready, out_valid, out_data, out_rd, out_ctrl, stall_cnt
  );
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: load-enabled payload register with async active-low reset to zero
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_o <= '0;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: 2-entry skid-buffered stage register with flush, bubble masking and stall counter
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_DATA = 3,
  parameter int RD_W   = 5,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst_n,
  pipe_stage_elastic_if.slave bus
);
  localparam int DW = DATA_W*N_DATA;
  localparam int PW = DW+RD_W+CTRL_W;
  state_t state_q, state_d;
  logic main_en, skid_en, from_skid, acc, drn;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign in_pl         = {bus.in_data, bus.in_rd, bus.in_ctrl};
  assign main_d        = from_skid ? skid_q : in_pl;
  assign bus.in_ready  = state_q != TWO;
  assign bus.out_valid = state_q != EMPTY;
  assign acc           = bus.in_valid & bus.in_ready;
  assign drn           = bus.out_valid & bus.out_ready;
  // bubbles must never carry RegWrite/MemWrite/jump controls downstream
  assign bus.out_data  = main_q[PW-1 -: DW];
  assign bus.out_rd    = bus.out_valid ? main_q[CTRL_W +: RD_W] : '0;
  assign bus.out_ctrl  = bus.out_valid ? main_q[CTRL_W-1:0] : '0;
  assign bus.stall_cnt = cnt_q;
  pipe_slot #(.W(PW)) u_main (.clk, .rst_n, .en_i(main_en), .d_i(main_d), .q_o(main_q));
  pipe_slot #(.W(PW)) u_skid (.clk, .rst_n, .en_i(skid_en), .d_i(in_pl),  .q_o(skid_q));
  always_comb begin
    state_d   = state_q;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    from_skid = 1'b0;
    unique case (state_q)
      EMPTY: if (acc) begin
        main_en = 1'b1;
        state_d = ONE;
      end
      ONE: if (acc && drn) main_en = 1'b1;
      else if (acc) begin
        skid_en = 1'b1;
        state_d = TWO;
      end else if (drn) state_d = EMPTY;
      TWO: if (drn) begin
        main_en   = 1'b1;
        from_skid = 1'b1;
        state_d   = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) state_d = EMPTY;
  end
  assign cnt_d = bus.stall_clr ? '0 :
                 (bus.out_valid && !bus.out_ready && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed scenario tasks with hand-computed expectations for pipe_stage_elastic
module tb_pipe_stage_elastic;
  import pipe_pkg::*;
  localparam int DATA_W = 32, N_DATA = 3, RD_W = 5, CTRL_W = 13, CNT_W = 4;
  localparam int DW = DATA_W*N_DATA;
  logic clk = 0, rst_n = 0;
  int n = 0, errs = 0;
  pipe_stage_elastic_if #(.DATA_W(DATA_W), .N_DATA(N_DATA), .RD_W(RD_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();
  pipe_stage_elastic #(.DATA_W(DATA_W), .N_DATA(N_DATA), .RD_W(RD_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [CTRL_W-1:0] RW;
  function automatic logic [DW-1:0] mk(input logic [31:0] w0);
    return {w0 << 4, ~w0, w0};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] w0);
    bus.in_valid = v;
    bus.in_data  = mk(w0);
    bus.in_rd    = w0[4:0];
    bus.in_ctrl  = RW;
  endtask
  task automatic test_reset();
    logic [DW+RD_W+CTRL_W+CNT_W+1:0] g;
    g = {bus.out_valid, bus.in_ready, bus.out_data, bus.out_rd, bus.out_ctrl, bus.stall_cnt};
    n++;
    if (g !== {1'b0, 1'b1, {(DW+RD_W+CTRL_W+CNT_W){1'b0}}}) begin
      errs++;
      $display("FAIL reset: got %h want valid=0 ready=1 rest=0", g);
    end
  endtask
  task automatic test_stream();
    logic [31:0] v [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    bus.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, i < 4 ? v[i] : 32'h0);
      if (i > 0) begin
        n++;
        if ({bus.out_valid, bus.in_ready, bus.out_data, bus.out_rd, bus.out_ctrl} !== {2'b11, mk(v[i-1]), v[i-1][4:0], RW}) begin
          errs++;
          $display("FAIL stream[%0d]: got v=%b r=%b d=%h rd=%h c=%h want d=%h", i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_rd, bus.out_ctrl, mk(v[i-1]));
        end
      end
      step();
    end
    n++;
    if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL stream_end: out_valid=%b want 0", bus.out_valid); end
  endtask
  task automatic test_backpressure();
    logic [31:0] e [3] = '{32'hA1, 32'hA2, 32'hA3};
    bus.stall_clr = 1; step(); bus.stall_clr = 0;
    bus.out_ready = 0;
    drive(1, 32'hA1); step();
    drive(1, 32'hA2);
    n++;
    if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_a2: in_ready=%b want 1", bus.in_ready); end
    step();
    drive(1, 32'hA3);
    for (int i = 0; i < 2; i++) begin
      n++;
      if ({bus.in_ready, bus.out_data} !== {1'b0, mk(32'hA1)}) begin
        errs++;
        $display("FAIL bp_hold[%0d]: in_ready=%b d=%h want 0 %h", i, bus.in_ready, bus.out_data, mk(32'hA1));
      end
      step();
    end
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, mk(e[i])}) begin
        errs++;
        $display("FAIL bp_drain[%0d]: v=%b d=%h want 1 %h", i, bus.out_valid, bus.out_data, mk(e[i]));
      end
      step();
      if (i == 0) drive(1, 32'hA3);
      else bus.in_valid = 0;
    end
    n++;
    if ({bus.out_valid, bus.stall_cnt} !== {1'b0, 4'd3}) begin
      errs++;
      $display("FAIL bp_stall_cnt: v=%b cnt=%0d want 0 3", bus.out_valid, bus.stall_cnt);
    end
  endtask
  task automatic test_flush();
    bus.out_ready = 0;
    drive(1, 32'hC1); step();
    drive(1, 32'hC2); step();
    drive(1, 32'hBEEF);
    bus.out_ready = 1;
    bus.flush = 1;
    n++;
    if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL flush_two_state: in_ready=%b want 0", bus.in_ready); end
    step();
    n++;
    if ({bus.out_valid, bus.out_ctrl, bus.out_rd, bus.in_ready} !== {1'b0, 13'h0, 5'h0, 1'b1}) begin
      errs++;
      $display("FAIL flush_two: v=%b c=%h rd=%h r=%b want 0 0 0 1", bus.out_valid, bus.out_ctrl, bus.out_rd, bus.in_ready);
    end
    bus.flush = 0;
    drive(1, 32'hD1); step();
    drive(1, 32'hBEEF); bus.flush = 1; step();
    bus.flush = 0; bus.in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      n++;
      if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL flush_one[%0d]: out_valid=%b want 0", i, bus.out_valid); end
      step();
    end
  endtask
  task automatic test_bubble();
    bus.in_valid = 0;
    bus.in_ctrl  = 13'h1FFF;
    bus.in_rd    = 5'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      n++;
      if ({bus.out_valid, bus.out_ctrl, bus.out_rd} !== 19'h0) begin
        errs++;
        $display("FAIL bubble[%0d]: v=%b c=%h rd=%h want 0", i, bus.out_valid, bus.out_ctrl, bus.out_rd);
      end
    end
  endtask
  task automatic test_stall_sat();
    bus.out_ready = 0;
    drive(1, 32'hE1);
    bus.stall_clr = 1; step();
    bus.stall_clr = 0; bus.in_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      n++;
      if (bus.stall_cnt !== CNT_W'(i > 15 ? 15 : i)) begin
        errs++;
        $display("FAIL stall_sat[%0d]: cnt=%0d want %0d", i, bus.stall_cnt, i > 15 ? 15 : i);
      end
    end
    bus.stall_clr = 1; step(); bus.stall_clr = 0;
    n++;
    if ({bus.out_valid, bus.stall_cnt} !== {1'b1, 4'd0}) begin
      errs++;
      $display("FAIL stall_clr: v=%b cnt=%0d want 1 0", bus.out_valid, bus.stall_cnt);
    end
  endtask
  task automatic test_async_reset();
    drive(1, 32'hF2); step();
    bus.in_valid = 0;
    n++;
    if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL arst_two: in_ready=%b want 0", bus.in_ready); end
    #2 rst_n = 0;
    #1;
    test_reset();
    #3 rst_n = 1;
    step();
    test_reset();
  endtask
  initial begin
    RW = '0;
    RW[REGWRITE] = 1'b1;
    bus.in_valid = 0; bus.in_data = '0; bus.in_rd = '0; bus.in_ctrl = '0;
    bus.flush = 0; bus.out_ready = 0; bus.stall_clr = 0;
    #12;
    test_reset();
    rst_n = 1;
    step();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_stall_sat();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
